dvi_video_controller: RTL and testbench
=======================================

DVI_VIDEO_CONTROLLER -- requirements
Module: dvi_video_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 1024, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 24, clocks after active region.
REQ-003 SHALL have parameter H_SYNC_PULSE, default 136, hsync width in clocks.
REQ-004 SHALL have parameter H_BACK_PORCH, default 160, clocks between hsync and active region.
REQ-005 SHALL have parameter V_VISIBLE, default 768, active lines per frame.
REQ-006 SHALL have parameters V_FRONT_PORCH, V_SYNC_PULSE and V_BACK_PORCH, defaults 3, 6 and 29, sizes in whole lines.
REQ-007 SHALL have parameter SYNC_POLARITY, default 0; 0 means active-low syncs, 1 means active-high.
REQ-008 SHALL have port clk, input, 1 bit, pixel clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port rst_b, input, 1 bit, reset that is asynchronous and active-low.
REQ-010 SHALL have port enable, input, 1 bit, run timing when high.
REQ-011 SHALL have port pix_data, input, 15 bits, RGB555 as {r[4:0], g[4:0], b[4:0]}.
REQ-012 SHALL have port pix_valid, input, 1 bit, pix_data is valid.
REQ-013 SHALL have port pix_ready, output, 1 bit, controller consumes pix_data this cycle.
REQ-014 SHALL have ports dvi_data_rise and dvi_data_fall, outputs, 12 bits each, words for the external DDR output register.
REQ-015 SHALL have ports dvi_de, dvi_h and dvi_v, outputs, 1 bit each, data enable, hsync and vsync.
REQ-016 SHALL have port frame_start, output, 1 bit, one-cycle pulse.
REQ-017 SHALL have ports underflow (output, 1 bit, sticky) and underflow_count (output, 16 bits).

Function
REQ-018 SHALL keep counters hcount in 0..HT-1 and vcount in 0..VT-1, where HT is the sum of the H parameters and VT is the sum of the V parameters (1344 and 806 by default).
REQ-019 SHALL advance hcount every enabled cycle; at HT-1 it wraps to 0 and vcount increments; vcount wraps to 0 after VT-1.
REQ-020 SHALL define horizontal regions by hcount: sync [0, HS), back porch [HS, HS+HBP), active [HS+HBP, HS+HBP+HV), front porch for the rest.
REQ-021 SHALL define vertical regions by vcount: sync [0, VS), back porch [VS, VS+VBP), active [VS+VBP, VS+VBP+VV), front porch for the rest.
REQ-022 SHALL assert vsync for every hcount while vcount is in the sync region, spanning exactly V_SYNC_PULSE*HT clocks.
REQ-023 SHALL assert hsync only while hcount is in the sync region and vcount is in the active region; hsync is suppressed during vertical blanking.
REQ-024 SHALL compute de = hcount active AND vcount active.
REQ-025 SHALL never assert more than one of hsync, vsync and de in the same cycle.
REQ-026 SHALL drive pix_ready combinationally equal to de, with no dependence on pix_valid.
REQ-027 SHALL, on any de cycle with pix_valid=1, register pix_data into the pixel stage.
REQ-028 SHALL, on any de cycle with pix_valid=0, register 0 (black), set underflow, and increment underflow_count, saturating at 0xFFFF.
REQ-029 SHALL register pixel, de, hsync and vsync through one common output stage, giving latency of exactly 1 clock from counter state to outputs, with all outputs aligned.
REQ-030 SHALL map syncs to pins as dvi_h = SYNC_POLARITY ? hsync : ~hsync, and dvi_v the same way.
REQ-031 SHALL set dvi_data_rise = {1'b0, r[4:0], g[4:3], 4'b0000}.
REQ-032 SHALL set dvi_data_fall = {g[2:0], b[4:0], 4'b0000}.
REQ-033 SHALL drive both data words to 0 whenever the registered de is 0.
REQ-034 SHALL pulse frame_start for 1 cycle on the output cycle corresponding to hcount=0, vcount=0, coincident with vsync assertion.
REQ-035 SHALL, when enable=0, hold hcount=0 and vcount=0 and drive outputs to their idle values: de=0, syncs deasserted, data 0, pix_ready=0.
REQ-036 SHALL, when enable rises, produce a first output cycle equal to hcount=0, vcount=0, which includes the frame_start pulse.
REQ-037 SHALL, on enable deasserted mid-frame, reach idle outputs on the next clock; the frame is abandoned, not completed.
REQ-038 SHALL clear underflow and underflow_count only by reset.

Reset
REQ-039 SHALL, while rst_b=0, asynchronously force: counters to 0; dvi_de=0; dvi_h and dvi_v deasserted (1 when SYNC_POLARITY=0); data words 0; frame_start=0; underflow=0; underflow_count=0.
REQ-040 SHALL treat reset asserted mid-line as an immediate abort; after release with enable=1, the next frame starts at hcount=0, vcount=0.

Verification
REQ-041 SHALL cover: defaults, enable=1, pix_valid=1 constant -> vsync low for 8064 clocks; 29*1344 clocks later first hsync low for 136 clocks; de high for 1024 clocks after 160 more; frame period 1083264 clocks.
REQ-042 SHALL cover: pix_data=15'h7FFF on the first active pixel -> dvi_data_rise=12'h7F0 and dvi_data_fall=12'hFF0 one clock after pix_ready.
REQ-043 SHALL cover: pix_valid=0 for 3 active cycles -> 3 black pixels, underflow=1, underflow_count=3, and sync timing unchanged.
REQ-044 SHALL cover: checker on every cycle of 2 frames -> de, hsync and vsync never overlap; hsync never asserted during vertical blanking.
REQ-045 SHALL cover: enable dropped at vcount=100, hcount=500 -> idle outputs next clock; re-enable -> frame_start pulse and vsync asserted on the first output cycle.
REQ-046 SHALL cover: rst_b asserted between clock edges during active video -> de=0 and syncs deasserted immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dvi_video_controller.sv
// dvi_video_controller: DVI raster timing generator with an RGB555 pixel stage and 12-bit DDR word output.
module dvi_video_controller #(
    parameter int H_VISIBLE     = 1024,
    parameter int H_FRONT_PORCH = 24,
    parameter int H_SYNC_PULSE  = 136,
    parameter int H_BACK_PORCH  = 160,
    parameter int V_VISIBLE     = 768,
    parameter int V_FRONT_PORCH = 3,
    parameter int V_SYNC_PULSE  = 6,
    parameter int V_BACK_PORCH  = 29,
    parameter int SYNC_POLARITY = 0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        enable,
    input  logic [14:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [11:0] dvi_data_rise,
    output logic [11:0] dvi_data_fall,
    output logic        dvi_de,
    output logic        dvi_h,
    output logic        dvi_v,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] underflow_count
);
    localparam int HT = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int VT = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int HA0 = H_SYNC_PULSE + H_BACK_PORCH;
    localparam int HA1 = HA0 + H_VISIBLE;
    localparam int VA0 = V_SYNC_PULSE + V_BACK_PORCH;
    localparam int VA1 = VA0 + V_VISIBLE;

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [14:0]   pix_q, pix_d;
    logic [15:0]   ucount_q, ucount_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, uf_q, uf_d;
    logic          h_end, h_act, v_act, de, starve;

    always_comb begin
        h_end    = int'(hcount_q) == HT - 1;
        h_act    = int'(hcount_q) >= HA0 && int'(hcount_q) < HA1;
        v_act    = int'(vcount_q) >= VA0 && int'(vcount_q) < VA1;
        de       = enable && h_act && v_act;
        starve   = de && !pix_valid;
        hcount_d = (!enable || h_end) ? '0 : hcount_q + HW'(1);
        vcount_d = !enable ? '0 : !h_end ? vcount_q : int'(vcount_q) == VT - 1 ? '0 : vcount_q + VW'(1);
        de_d     = de;
        // hsync only on active lines so it never collides with vsync
        hs_d     = enable && int'(hcount_q) < H_SYNC_PULSE && v_act;
        vs_d     = enable && int'(vcount_q) < V_SYNC_PULSE;
        fs_d     = enable && hcount_q == '0 && vcount_q == '0;
        pix_d    = (de && pix_valid) ? pix_data : '0;
        uf_d     = uf_q || starve;
        ucount_d = (starve && ucount_q != 16'hFFFF) ? ucount_q + 16'd1 : ucount_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hcount_q <= '0;
            vcount_q <= '0;
            pix_q    <= '0;
            de_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fs_q     <= 1'b0;
            uf_q     <= 1'b0;
            ucount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            pix_q    <= pix_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            uf_q     <= uf_d;
            ucount_q <= ucount_d;
        end
    end

    assign pix_ready       = de;
    assign dvi_de          = de_q;
    assign dvi_h           = (SYNC_POLARITY != 0) ? hs_q : ~hs_q;
    assign dvi_v           = (SYNC_POLARITY != 0) ? vs_q : ~vs_q;
    assign dvi_data_rise   = de_q ? {1'b0, pix_q[14:10], pix_q[9:8], 4'b0000} : '0;
    assign dvi_data_fall   = de_q ? {pix_q[7:5], pix_q[4:0], 4'b0000} : '0;
    assign frame_start     = fs_q;
    assign underflow       = uf_q;
    assign underflow_count = ucount_q;
endmodule

// File: tb/tb_dvi_video_controller.sv
// tb_dvi_video_controller: directed checks of a reduced 17x9 raster plus underflow, enable and async reset sequences.
module tb_dvi_video_controller;
    localparam int HT = 17;
    localparam int VT = 9;

    logic        clk = 1'b0;
    logic        rst_b, enable, pix_valid, pix_ready;
    logic [14:0] pix_data;
    logic [11:0] dvi_data_rise, dvi_data_fall;
    logic        dvi_de, dvi_h, dvi_v, frame_start, underflow;
    logic [15:0] underflow_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pos = 0;
    logic chk_en = 1'b0;

    typedef struct {
        int hc;
        int vc;
        logic de, hp, vp, fs;
        logic [11:0] rise, fall;
    } vec_t;
    vec_t vecs[$];

    dvi_video_controller #(
        .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(4),
        .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
        .SYNC_POLARITY(0)
    ) dut (
        .clk(clk), .rst_b(rst_b), .enable(enable), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .dvi_data_rise(dvi_data_rise), .dvi_data_fall(dvi_data_fall),
        .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v), .frame_start(frame_start),
        .underflow(underflow), .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " de"}, 32'(dvi_de), 0);
        check({tag, " h"}, 32'(dvi_h), 1);
        check({tag, " v"}, 32'(dvi_v), 1);
        check({tag, " rise"}, 32'(dvi_data_rise), 0);
        check({tag, " fall"}, 32'(dvi_data_fall), 0);
        check({tag, " fs"}, 32'(frame_start), 0);
    endtask

    // active-low pins: sync asserted when the pin is 0; hsync only on lines 4..7
    always @(negedge clk) begin
        if (chk_en) begin
            pos = frame_start ? 0 : pos + 1;
            check("overlap", 32'(int'(dvi_de) + int'(!dvi_h) + int'(!dvi_v) > 1), 0);
            check("hsync_vblank", 32'(!dvi_h && !((pos / HT) % VT >= 4 && (pos / HT) % VT < 8)), 0);
        end
    end

    initial begin
        int cur, t0;
        vecs.push_back('{0, 0, 0, 1, 0, 1, 12'h0, 12'h0});
        vecs.push_back('{1, 0, 0, 1, 0, 0, 12'h0, 12'h0});
        vecs.push_back('{16, 1, 0, 1, 0, 0, 12'h0, 12'h0});
        vecs.push_back('{0, 2, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{7, 3, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{0, 4, 0, 0, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{2, 4, 0, 0, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{3, 4, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{6, 4, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{7, 4, 1, 1, 1, 0, 12'h7F0, 12'hFF0});
        vecs.push_back('{14, 7, 1, 1, 1, 0, 12'h7F0, 12'hFF0});
        vecs.push_back('{15, 7, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{0, 8, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{7, 8, 0, 1, 1, 0, 12'h0, 12'h0});
        vecs.push_back('{0, 9, 0, 1, 0, 1, 12'h0, 12'h0});

        rst_b = 1'b0;
        enable = 1'b0;
        pix_data = 15'h7FFF;
        pix_valid = 1'b1;
        #3;
        check_idle("reset");
        check("reset uf", 32'(underflow), 0);
        check("reset ucnt", 32'(underflow_count), 0);
        @(negedge clk) rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("disabled");
        check("disabled ready", 32'(pix_ready), 0);

        enable = 1'b1;
        chk_en = 1'b1;
        cur = -1;
        foreach (vecs[i]) begin
            while (cur < vecs[i].vc * HT + vecs[i].hc) begin
                @(negedge clk);
                cur++;
            end
            check($sformatf("vec%0d de", i), 32'(dvi_de), 32'(vecs[i].de));
            check($sformatf("vec%0d h", i), 32'(dvi_h), 32'(vecs[i].hp));
            check($sformatf("vec%0d v", i), 32'(dvi_v), 32'(vecs[i].vp));
            check($sformatf("vec%0d fs", i), 32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("vec%0d rise", i), 32'(dvi_data_rise), 32'(vecs[i].rise));
            check($sformatf("vec%0d fall", i), 32'(dvi_data_fall), 32'(vecs[i].fall));
        end

        for (int i = 0; i < 400 && !pix_ready; i++) @(negedge clk);
        check("wait pix_ready", 32'(pix_ready), 1);
        pix_data = 15'h56CB;
        @(negedge clk);
        check("pat de", 32'(dvi_de), 1);
        check("pat rise", 32'(dvi_data_rise), 12'h560);
        check("pat fall", 32'(dvi_data_fall), 12'hCB0);
        check("pre uf", 32'(underflow), 0);
        pix_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("black%0d de", i), 32'(dvi_de), 1);
            check($sformatf("black%0d rise", i), 32'(dvi_data_rise), 0);
            check($sformatf("black%0d fall", i), 32'(dvi_data_fall), 0);
            check($sformatf("black%0d ucnt", i), 32'(underflow_count), 32'(i));
        end
        pix_valid = 1'b1;
        pix_data = 15'h7FFF;
        @(negedge clk);
        check("uf sticky", 32'(underflow), 1);
        check("ucnt held", 32'(underflow_count), 3);
        check("resume rise", 32'(dvi_data_rise), 12'h7F0);

        for (int i = 0; i < 400 && !frame_start; i++) @(negedge clk);
        check("wait fs0", 32'(frame_start), 1);
        t0 = cyc;
        @(negedge clk);
        for (int i = 0; i < 400 && !frame_start; i++) @(negedge clk);
        check("wait fs1", 32'(frame_start), 1);
        check("frame period", 32'(cyc - t0), 153);
        chk_en = 1'b0;

        repeat (94) @(negedge clk);
        check("mid ready", 32'(pix_ready), 1);
        check("mid de", 32'(dvi_de), 1);
        enable = 1'b0;
        #1;
        check("drop ready", 32'(pix_ready), 0);
        @(negedge clk);
        check_idle("drop");
        repeat (3) @(negedge clk);
        check_idle("held");
        enable = 1'b1;
        @(negedge clk);
        check("reen fs", 32'(frame_start), 1);
        check("reen v", 32'(dvi_v), 0);
        check("reen de", 32'(dvi_de), 0);
        check("reen h", 32'(dvi_h), 1);

        for (int i = 0; i < 400 && !dvi_de; i++) @(negedge clk);
        check("wait de", 32'(dvi_de), 1);
        #2 rst_b = 1'b0;
        #1;
        check_idle("async");
        check("async uf", 32'(underflow), 0);
        check("async ucnt", 32'(underflow_count), 0);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check("post rst fs", 32'(frame_start), 1);
        check("post rst v", 32'(dvi_v), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
